// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary GCD engine.
package gcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StStrip,
    StOdd,
    StFinal,
    StDone
  } gcd_state_e;

  // Width of the common power-of-two shift count K.
  function automatic int unsigned k_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/gcd_binary_dp.sv
// Datapath for the binary GCD engine: A/B/K registers, comparator, subtractor, shifters.
module gcd_binary_dp
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             strip,
  input  logic             shr_a,
  input  logic             shr_b,
  input  logic             sub_a,
  input  logic             sub_b,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a_zero,
  output logic             b_zero,
  output logic             a_odd,
  output logic             b_odd,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic [WIDTH-1:0] a_or_b,
  output logic [WIDTH-1:0] final_val
);

  localparam int unsigned KW = k_width(WIDTH);

  logic [WIDTH-1:0] a_q, b_q;
  logic [KW-1:0]    k_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
      k_q <= '0;
    end else if (strip) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
      k_q <= k_q + 1'b1;
    end else if (shr_a) begin
      a_q <= a_q >> 1;
    end else if (shr_b) begin
      b_q <= b_q >> 1;
    end else if (sub_a) begin
      a_q <= a_q - b_q;
    end else if (sub_b) begin
      b_q <= b_q - a_q;
    end
  end

  assign a_zero    = (a_q == '0);
  assign b_zero    = (b_q == '0);
  assign a_odd     = a_q[0];
  assign b_odd     = b_q[0];
  assign a_eq_b    = (a_q == b_q);
  assign a_gt_b    = (a_q > b_q);
  assign a_or_b    = a_q | b_q;
  // Restoring the stripped common factor cannot overflow: it never exceeds the larger operand.
  assign final_val = a_q << k_q;

endmodule

// File: rtl/gcd_binary.sv
// Binary (Stein) GCD engine: control FSM, saturating cycle counter and output registers.
module gcd_binary
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] cycles
);

  gcd_state_e state_q, state_d;

  logic load, strip, shr_a, shr_b, sub_a, sub_b;
  logic a_zero, b_zero, a_odd, b_odd, a_eq_b, a_gt_b;
  logic [WIDTH-1:0] a_or_b, final_val;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc, cycles_q;
  logic             counting;

  gcd_binary_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .strip    (strip),
    .shr_a    (shr_a),
    .shr_b    (shr_b),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .a_in     (a_in),
    .b_in     (b_in),
    .a_zero   (a_zero),
    .b_zero   (b_zero),
    .a_odd    (a_odd),
    .b_odd    (b_odd),
    .a_eq_b   (a_eq_b),
    .a_gt_b   (a_gt_b),
    .a_or_b   (a_or_b),
    .final_val(final_val)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    strip   = 1'b0;
    shr_a   = 1'b0;
    shr_b   = 1'b0;
    sub_a   = 1'b0;
    sub_b   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: state_d = (a_zero || b_zero) ? StDone : StStrip;
      StStrip: begin
        if (!a_odd && !b_odd) strip = 1'b1;
        else state_d = StOdd;
      end
      StOdd: begin
        if (!a_odd)      shr_a = 1'b1;
        else if (!b_odd) shr_b = 1'b1;
        else if (a_eq_b) state_d = StFinal;
        else if (a_gt_b) sub_a = 1'b1;
        else             sub_b = 1'b1;
      end
      StFinal: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign counting = (state_q != StIdle) && (state_q != StDone);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) cnt_q <= '0;
      else if (counting) cnt_q <= cnt_inc;
      // The edge entering DONE is itself counted, hence cnt_inc rather than cnt_q.
      if (state_q == StCheck && state_d == StDone) begin
        result_q <= a_or_b;
        cycles_q <= cnt_inc;
      end else if (state_q == StFinal) begin
        result_q <= final_val;
        cycles_q <= cnt_inc;
      end
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign cycles = cycles_q;

endmodule

// File: doc/gcd_binary.md
# gcd_binary

Parametrised greatest-common-divisor engine. It is the successor to the fixed 32-bit subtractive `gcd` unit and uses the same start/done handshake, so it drops into the existing self-checking bench flow. It implements the binary (Stein) algorithm with one shift or subtract per clock. It adds a busy indication, explicit zero-operand handling, and a per-operation cycle count for throughput characterisation.

## Interface
- `WIDTH`, default 32: operand and result width in bits (≥2).
- `CNT_W`, default 16: width of the saturating cycle counter.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: request; sampled only in IDLE.
- `a_in` input WIDTH: unsigned operand A; captured on the accepting edge.
- `b_in` input WIDTH: unsigned operand B; captured on the accepting edge.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse; `result` and `cycles` are valid from this cycle.
- `result` output WIDTH: gcd(A,B); held until the next DONE.
- `cycles` output CNT_W: clock edges from the accepting edge to the edge entering DONE; saturates at all-ones.

## Operation
- Internal registers: A and B (WIDTH bits each) and shift count K (`$clog2(WIDTH+1)` bits).
- IDLE: on `start`=1, load A=`a_in`, B=`b_in`, K=0, clear the counter, then go to CHECK. When `start`=0, stay in IDLE.
- CHECK: if A==0 or B==0, write `result`=A|B and go to DONE. Otherwise go to STRIP.
- STRIP:
  - If A[0]==0 and B[0]==0: shift A and B right by 1, K++, stay in STRIP.
  - Otherwise go to ODD.
- ODD, one action per cycle, first matching rule wins:
  - A even: A>>=1.
  - B even: B>>=1.
  - A==B: go to FINAL.
  - A>B: A=A−B.
  - Otherwise: B=B−A.
- FINAL: write `result`=A<<K, then go to DONE.
- DONE: `done`=1 for exactly this cycle, then go unconditionally to IDLE.
- Arithmetic rules:
  - Subtraction is always larger minus smaller, so there is no borrow.
  - A<<K never exceeds the larger original operand, so there is no overflow and no width extension is needed.
- gcd(0,0) is defined as 0. gcd(x,0) = gcd(0,x) = x.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `cycles`=0, state IDLE.
- `busy` rises in the cycle after the accepting edge. It falls in the cycle after DONE, i.e. back in IDLE.
- `start` is ignored while `busy`=1, including during the DONE cycle. Back-to-back operations therefore need one IDLE cycle between `done` and the next `start`.
- `a_in` and `b_in` are don't-care except on the accepting edge.
- Minimum latency is 1 edge (a zero operand): CHECK then DONE.
- Worst case is roughly 3·WIDTH+3 edges.
- The counter increments on every edge while not in IDLE or DONE, and saturates rather than wrapping.
- When `reset` is asserted mid-operation, the block immediately returns to IDLE with all outputs at reset values. No `done` is produced for the aborted operation.

## Structure
- Shared package `gcd_pkg`:
  - `gcd_state_e` enum: IDLE, CHECK, STRIP, ODD, FINAL, DONE.
  - Helper function for the K width.
- One sub-module, `gcd_binary_dp`, holds the datapath:
  - A, B and K registers.
  - Comparator, subtractor and shifters.
  - Driven by one-hot control from the FSM in the top level, with status flags A==0, B==0, A[0], B[0], A==B, A>B returned to the FSM.
- `cycles` counter and output registers live in the top level.

## Test plan
- WIDTH=32, start with (12,18) → `done` 8 edges after acceptance; `result`=6, `cycles`=8.
- (0,0) → `result`=0, `cycles`=1. (0,35) → `result`=35. (35,0) → `result`=35.
- (1024,4096) → `result`=1024, confirming K=10 is restored. (4294967295,1) → `result`=1, no overflow, `cycles` < 100.
- WIDTH=8 instance with (255,85) → `result`=85. CNT_W=4 instance with a long case → `cycles` saturates at 15.
- Pulse `start` with new operands while `busy`=1, and again during the `done` cycle → ignored; the first result is unchanged and no extra `done` occurs.
- Assert `reset` mid-STRIP for (12,18) → `busy`, `done`, `result` and `cycles` all go to 0 asynchronously. A new (9,6) after release → `result`=3.
